// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the multi-cycle 32x32 multiply sequencer.
// Partial products are indexed lo*lo, lo*hi, hi*lo, hi*hi in issue order.
package mul_seq_pkg;

  localparam int unsigned HALF_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef logic [1:0] prod_idx_t;

  localparam prod_idx_t IDX_LL = 2'd0;
  localparam prod_idx_t IDX_LH = 2'd1;
  localparam prod_idx_t IDX_HL = 2'd2;
  localparam prod_idx_t IDX_HH = 2'd3;

  // Alignment of each partial product, in units of HALF_W bits.
  localparam int unsigned SHIFT_UNITS_LL = 0;
  localparam int unsigned SHIFT_UNITS_LH = 1;
  localparam int unsigned SHIFT_UNITS_HL = 1;
  localparam int unsigned SHIFT_UNITS_HH = 2;

  typedef struct packed {
    logic      valid;
    prod_idx_t idx;
  } tag_t;

  function automatic int unsigned prodShiftUnits(input prod_idx_t idx);
    int unsigned units;
    case (idx)
      IDX_LL:  units = SHIFT_UNITS_LL;
      IDX_LH:  units = SHIFT_UNITS_LH;
      IDX_HL:  units = SHIFT_UNITS_HL;
      default: units = SHIFT_UNITS_HH;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/mul_seq_mul16.sv
// Shared HALF_W x HALF_W multiplier cell with per-operand sign control and
// MUL_LATENCY pipeline stages; intended to map onto one device DSP block.
module mul_seq_mul16 #(
  parameter int HALF_W      = 16,
  parameter int MUL_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [HALF_W-1:0]     i_a,
  input  logic [HALF_W-1:0]     i_b,
  input  logic                  i_signa,
  input  logic                  i_signb,
  output logic [2*HALF_W-1:0]   o_p
);

  logic [2*HALF_W-1:0] w_aExt;
  logic [2*HALF_W-1:0] w_bExt;
  logic [2*HALF_W-1:0] w_prod;
  logic [2*HALF_W-1:0] r_stage [MUL_LATENCY];

  // Low 2*HALF_W bits of a two's-complement product do not depend on
  // signedness once both operands are extended to that width.
  assign w_aExt = {{HALF_W{i_signa & i_a[HALF_W-1]}}, i_a};
  assign w_bExt = {{HALF_W{i_signb & i_b[HALF_W-1]}}, i_b};
  assign w_prod = w_aExt * w_bExt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      if (i_en) begin
        r_stage[0] <= w_prod;
      end
      for (int i = 1; i < MUL_LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_p = r_stage[MUL_LATENCY-1];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 32x32 -> 64 multiply sequencer: issues four partial products
// through one shared 16x16 cell and accumulates them into a 64-bit result.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int HALF_W      = HALF_W_DEF,
  parameter int MUL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2*HALF_W-1:0]   req_src1,
  input  logic [2*HALF_W-1:0]   req_src2,
  input  logic                  req_src1_signed,
  input  logic                  req_src2_signed,
  input  logic                  flush,
  output logic                  busy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [4*HALF_W-1:0]   rsp_data
);

  localparam int OP_W  = 2 * HALF_W;
  localparam int RES_W = 4 * HALF_W;

  state_t             r_state;
  prod_idx_t          r_cnt;
  logic [OP_W-1:0]    r_src1;
  logic [OP_W-1:0]    r_src2;
  logic               r_src1Signed;
  logic               r_src2Signed;
  logic [RES_W-1:0]   r_acc;
  logic               r_reqReady;
  logic               r_busy;
  logic               r_rspValid;
  tag_t               r_tag [MUL_LATENCY];

  logic               w_issue;
  logic [HALF_W-1:0]  w_mulA;
  logic [HALF_W-1:0]  w_mulB;
  logic               w_signA;
  logic               w_signB;
  logic [OP_W-1:0]    w_prod;
  tag_t               w_tagOut;
  logic               w_prodSigned;
  logic [RES_W-1:0]   w_prodExt;
  logic [RES_W-1:0]   w_addend;
  logic [RES_W-1:0]   w_accNext;

  // cnt bit 1 selects the src1 half, bit 0 the src2 half; a half is only
  // signed when it is the upper half of a signed operand.
  assign w_issue = (r_state == ISSUE);
  assign w_mulA  = r_cnt[1] ? r_src1[OP_W-1:HALF_W] : r_src1[HALF_W-1:0];
  assign w_mulB  = r_cnt[0] ? r_src2[OP_W-1:HALF_W] : r_src2[HALF_W-1:0];
  assign w_signA = r_cnt[1] & r_src1Signed;
  assign w_signB = r_cnt[0] & r_src2Signed;

  mul_seq_mul16 #(
    .HALF_W      (HALF_W),
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_en    (w_issue),
    .i_a     (w_mulA),
    .i_b     (w_mulB),
    .i_signa (w_signA),
    .i_signb (w_signB),
    .o_p     (w_prod)
  );

  assign w_tagOut     = r_tag[MUL_LATENCY-1];
  assign w_prodSigned = (w_tagOut.idx[1] & r_src1Signed) | (w_tagOut.idx[0] & r_src2Signed);
  assign w_prodExt    = {{OP_W{w_prodSigned & w_prod[OP_W-1]}}, w_prod};
  assign w_addend     = w_tagOut.valid ? (w_prodExt << (prodShiftUnits(w_tagOut.idx) * HALF_W)) : '0;
  assign w_accNext    = r_acc + w_addend;

  // Tags travel every cycle so the last product can drain while the
  // multiplier input stage is no longer enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: w_issue, idx: r_cnt};
      for (int i = 1; i < MUL_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= IDX_LL;
      r_src1       <= '0;
      r_src2       <= '0;
      r_src1Signed <= 1'b0;
      r_src2Signed <= 1'b0;
      r_acc        <= '0;
      r_reqReady   <= 1'b1;
      r_busy       <= 1'b0;
      r_rspValid   <= 1'b0;
    end else if (flush && (r_state != IDLE)) begin
      r_state    <= IDLE;
      r_cnt      <= IDX_LL;
      r_acc      <= '0;
      r_reqReady <= 1'b1;
      r_busy     <= 1'b0;
      r_rspValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && !flush) begin
            r_state      <= ISSUE;
            r_cnt        <= IDX_LL;
            r_src1       <= req_src1;
            r_src2       <= req_src2;
            r_src1Signed <= req_src1_signed;
            r_src2Signed <= req_src2_signed;
            r_acc        <= '0;
            r_reqReady   <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        ISSUE: begin
          r_acc <= w_accNext;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == IDX_HH) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_acc <= w_accNext;
          if (w_tagOut.valid && (w_tagOut.idx == IDX_HH)) begin
            r_state    <= RESP;
            r_rspValid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state    <= IDLE;
            r_rspValid <= 1'b0;
            r_busy     <= 1'b0;
            r_reqReady <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_reqReady;
  assign busy      = r_busy;
  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_acc;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: latency-1 and latency-3 instances checked every cycle
// against a behavioural model, plus hand-computed directed expectations.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        resetN    [2];
  logic        reqValid  [2];
  logic        reqReady  [2];
  logic [31:0] src1      [2];
  logic [31:0] src2      [2];
  logic        src1S     [2];
  logic        src2S     [2];
  logic        flushIn   [2];
  logic        busyOut   [2];
  logic        rspValid  [2];
  logic        rspReady  [2];
  logic [63:0] rspData   [2];

  int          total = 0;
  int          bad   = 0;
  logic        checkEn = 1'b0;

  int          mPhase [2];
  int          mEdges [2];
  logic [63:0] mProd  [2];
  logic [63:0] mData  [2];
  logic        mKnown [2];

  always #5 clk = ~clk;

  mul_seq_ctrl #(.HALF_W(16), .MUL_LATENCY(1)) dut0 (
    .clk(clk), .reset_n(resetN[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .req_src1(src1[0]), .req_src2(src2[0]), .req_src1_signed(src1S[0]), .req_src2_signed(src2S[0]),
    .flush(flushIn[0]), .busy(busyOut[0]), .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]),
    .rsp_data(rspData[0])
  );

  mul_seq_ctrl #(.HALF_W(16), .MUL_LATENCY(3)) dut1 (
    .clk(clk), .reset_n(resetN[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .req_src1(src1[1]), .req_src2(src2[1]), .req_src1_signed(src1S[1]), .req_src2_signed(src2S[1]),
    .flush(flushIn[1]), .busy(busyOut[1]), .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]),
    .rsp_data(rspData[1])
  );

  function automatic int latOf(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic sa, input logic sb);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 computing, 2 holding the response.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!resetN[g]) begin
        mPhase[g] = 0;
        mEdges[g] = 0;
        mData[g]  = '0;
        mKnown[g] = 1'b1;
      end else if (mPhase[g] == 0) begin
        if (reqValid[g] && !flushIn[g]) begin
          mPhase[g] = 1;
          mEdges[g] = 0;
          mProd[g]  = refProduct(src1[g], src2[g], src1S[g], src2S[g]);
          mKnown[g] = 1'b0;
        end
      end else if (flushIn[g]) begin
        mPhase[g] = 0;
        mData[g]  = '0;
        mKnown[g] = 1'b1;
      end else if (mPhase[g] == 1) begin
        mEdges[g]++;
        if (mEdges[g] == 4 + latOf(g)) begin
          mPhase[g] = 2;
          mData[g]  = mProd[g];
          mKnown[g] = 1'b1;
        end
      end else if (rspReady[g]) begin
        mPhase[g] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      for (int g = 0; g < 2; g++) begin
        checkOutput($sformatf("u%0d.req_ready", g), {63'h0, reqReady[g]}, {63'h0, mPhase[g] == 0});
        checkOutput($sformatf("u%0d.busy", g), {63'h0, busyOut[g]}, {63'h0, mPhase[g] != 0});
        checkOutput($sformatf("u%0d.rsp_valid", g), {63'h0, rspValid[g]}, {63'h0, mPhase[g] == 2});
        if (mKnown[g]) begin
          checkOutput($sformatf("u%0d.rsp_data", g), rspData[g], mData[g]);
        end
      end
    end
  end

  // Presents a request and returns 1 time unit after its accepting edge.
  task automatic applyStimulus(input int g, input logic [31:0] a, input logic [31:0] b,
                               input logic sa, input logic sb);
    int n;
    @(negedge clk);
    src1[g] = a;
    src2[g] = b;
    src1S[g] = sa;
    src2S[g] = sb;
    reqValid[g] = 1'b1;
    n = 0;
    while (!reqReady[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept.req_ready", {63'h0, reqReady[g]}, 64'd1);
    @(posedge clk);
    #1 reqValid[g] = 1'b0;
  endtask

  task automatic waitResp(input int g, input int expEdges, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!rspValid[g] && n < 40);
    checkOutput({tag, ".latency"}, 64'(n), 64'(expEdges));
  endtask

  task automatic finishResp(input int g);
    @(negedge clk);
    rspReady[g] = 1'b1;
    @(posedge clk);
    #1 rspReady[g] = 1'b0;
  endtask

  task automatic runOp(input int g, input logic [31:0] a, input logic [31:0] b, input logic sa,
                       input logic sb, input logic [63:0] expData, input int expLat, input string tag);
    applyStimulus(g, a, b, sa, sb);
    waitResp(g, expLat, tag);
    checkOutput({tag, ".data"}, rspData[g], expData);
    checkOutput({tag, ".busy"}, {63'h0, busyOut[g]}, 64'd1);
    finishResp(g);
  endtask

  task automatic resetInDrain(input int g, input string tag);
    applyStimulus(g, 32'h0003_0003, 32'h0005_0005, 1'b0, 1'b0);
    repeat (4 + latOf(g) / 2) @(posedge clk);
    @(negedge clk);
    checkOutput({tag, ".pre.busy"}, {63'h0, busyOut[g]}, 64'd1);
    #2 resetN[g] = 1'b0;
    #1;
    checkOutput({tag, ".rsp_valid"}, {63'h0, rspValid[g]}, 64'd0);
    checkOutput({tag, ".busy"}, {63'h0, busyOut[g]}, 64'd0);
    checkOutput({tag, ".rsp_data"}, rspData[g], 64'd0);
    checkOutput({tag, ".req_ready"}, {63'h0, reqReady[g]}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    #1 resetN[g] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      resetN[g] = 1'b0;
      reqValid[g] = 1'b0;
      src1[g] = '0;
      src2[g] = '0;
      src1S[g] = 1'b0;
      src2S[g] = 1'b0;
      flushIn[g] = 1'b0;
      rspReady[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    resetN[0] = 1'b1;
    resetN[1] = 1'b1;
    checkEn = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput("reset.req_ready", {63'h0, reqReady[g]}, 64'd1);
      checkOutput("reset.busy", {63'h0, busyOut[g]}, 64'd0);
      checkOutput("reset.rsp_valid", {63'h0, rspValid[g]}, 64'd0);
      checkOutput("reset.rsp_data", rspData[g], 64'd0);
    end

    runOp(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 5, "l1.uu");
    runOp(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, 5, "l1.ss");
    runOp(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 7, "l3.uu");
    runOp(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, 7, "l3.ss");
    runOp(1, 32'h8000_0000, 32'h0000_0002, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0000, 7, "l3.su");

    // Response held off for 10 cycles, then a queued request right behind it.
    applyStimulus(0, 32'h8000_0000, 32'h0000_0002, 1'b1, 1'b0);
    waitResp(0, 5, "hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold.rsp_valid", {63'h0, rspValid[0]}, 64'd1);
      checkOutput("hold.req_ready", {63'h0, reqReady[0]}, 64'd0);
      checkOutput("hold.rsp_data", rspData[0], 64'hFFFF_FFFF_0000_0000);
    end
    @(negedge clk);
    rspReady[0] = 1'b1;
    src1[0] = 32'd3;
    src2[0] = 32'd5;
    src1S[0] = 1'b0;
    src2S[0] = 1'b0;
    reqValid[0] = 1'b1;
    @(posedge clk);
    #1 rspReady[0] = 1'b0;
    checkOutput("hold.idle.req_ready", {63'h0, reqReady[0]}, 64'd1);
    checkOutput("hold.idle.rsp_valid", {63'h0, rspValid[0]}, 64'd0);
    checkOutput("hold.idle.rsp_data", rspData[0], 64'hFFFF_FFFF_0000_0000);
    @(posedge clk);
    #1 reqValid[0] = 1'b0;
    checkOutput("next.accept.busy", {63'h0, busyOut[0]}, 64'd1);
    checkOutput("next.accept.req_ready", {63'h0, reqReady[0]}, 64'd0);
    waitResp(0, 5, "next");
    checkOutput("next.data", rspData[0], 64'd15);
    finishResp(0);

    // Flush on the third ISSUE cycle, then a clean operation.
    applyStimulus(0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    flushIn[0] = 1'b1;
    @(posedge clk);
    #1 flushIn[0] = 1'b0;
    checkOutput("flush.req_ready", {63'h0, reqReady[0]}, 64'd1);
    checkOutput("flush.busy", {63'h0, busyOut[0]}, 64'd0);
    checkOutput("flush.rsp_data", rspData[0], 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("flush.no_rsp", {63'h0, rspValid[0]}, 64'd0);
    end
    runOp(0, 32'h0001_2345, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_2345_0000, 5, "after_flush");

    // Flush in IDLE blocks a simultaneous request.
    @(negedge clk);
    flushIn[0] = 1'b1;
    src1[0] = 32'd7;
    src2[0] = 32'd9;
    reqValid[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_flush.busy", {63'h0, busyOut[0]}, 64'd0);
    checkOutput("idle_flush.req_ready", {63'h0, reqReady[0]}, 64'd1);
    flushIn[0] = 1'b0;
    reqValid[0] = 1'b0;

    // Flush wins over a simultaneous response handshake.
    applyStimulus(0, 32'd6, 32'd7, 1'b0, 1'b0);
    waitResp(0, 5, "resp_flush");
    checkOutput("resp_flush.pre.data", rspData[0], 64'd42);
    @(negedge clk);
    flushIn[0] = 1'b1;
    rspReady[0] = 1'b1;
    @(posedge clk);
    #1;
    flushIn[0] = 1'b0;
    rspReady[0] = 1'b0;
    checkOutput("resp_flush.rsp_valid", {63'h0, rspValid[0]}, 64'd0);
    checkOutput("resp_flush.rsp_data", rspData[0], 64'd0);

    resetInDrain(0, "rst_drain.l1");
    resetInDrain(1, "rst_drain.l3");
    runOp(1, 32'h0001_2345, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_2345_0000, 7, "l3.after_rst");

    repeat (3) @(negedge clk);
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
